// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller: timed power-on init, then on request
// snapshots a ROWS x COLS text frame and writes it row by row over an 8- or 4-bit bus.
module lcd_text_ctrl #(
    parameter int ROWS      = 2,
    parameter int COLS      = 16,
    parameter int BUS4      = 0,
    parameter int E_CYCLES  = 12,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 80000,
    parameter int INIT_WAIT = 750000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [8*ROWS*COLS-1:0]   text,
    input  logic                     update,
    output logic                     busy,
    output logic                     done,
    output logic                     lcd_e,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic [7:0]               lcd_db
);

    localparam int MAX_A = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int MAX_B = (CMD_WAIT > E_CYCLES) ? CMD_WAIT : E_CYCLES;
    localparam int MAXW  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAXW + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW    = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [CW-1:0] INIT_END = CW'(INIT_WAIT - 1);
    localparam logic [CW-1:0] E_END    = CW'(E_CYCLES - 1);
    localparam logic [CW-1:0] CMD_END  = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_END  = CW'(CLR_WAIT - 1);
    localparam logic [2:0]    INIT_LAST = (BUS4 != 0) ? 3'd7 : 3'd3;

    typedef enum logic [2:0] {T_INIT_DLY, T_INIT_SEQ, T_IDLE, T_CURSOR, T_CHARS} top_t;
    typedef enum logic [1:0] {P_SETUP, P_EHI, P_HOLD, P_WAIT} ph_t;

    top_t                  top_q, top_d;
    ph_t                   ph_q, ph_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [RW-1:0]         row_q, row_d;
    logic [KW-1:0]         col_q, col_d;
    logic                  nib_q, nib_d;
    logic [8*ROWS*COLS-1:0] frame_q;

    logic [7:0]  cur_byte;
    logic [7:0]  ch;
    logic [31:0] char_idx;
    logic        single;
    logic        active;
    logic        last_row, last_col;
    logic        byte_end;
    logic [CW-1:0] wait_end;

    function automatic logic [7:0] row_base(input logic [RW-1:0] r);
        case (32'(r))
            0:       row_base = 8'h00;
            1:       row_base = 8'h40;
            2:       row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q   <= T_INIT_DLY;
            ph_q    <= P_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            nib_q   <= 1'b0;
            frame_q <= '0;
        end else begin
            top_q <= top_d;
            ph_q  <= ph_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            row_q <= row_d;
            col_q <= col_d;
            nib_q <= nib_d;
            if (top_q == T_IDLE && update) frame_q <= text;
        end
    end

    // Byte currently on the bus is derived from state, so it cannot move mid-transfer.
    always_comb begin
        cur_byte = '0;
        single   = 1'b0;
        ch       = '0;
        char_idx = 32'(row_q) * COLS + 32'(col_q);
        for (int unsigned k = 0; k < ROWS * COLS; k++) begin
            if (char_idx == k) ch = frame_q[8*k +: 8];
        end
        case (top_q)
            T_INIT_SEQ: begin
                if (BUS4 != 0) begin
                    single = (idx_q < 3'd4);
                    case (idx_q)
                        3'd0, 3'd1, 3'd2: cur_byte = 8'h30;
                        3'd3:             cur_byte = 8'h20;
                        3'd4:             cur_byte = 8'h28;
                        3'd5:             cur_byte = 8'h0C;
                        3'd6:             cur_byte = 8'h01;
                        default:          cur_byte = 8'h06;
                    endcase
                end else begin
                    case (idx_q)
                        3'd0:    cur_byte = 8'h38;
                        3'd1:    cur_byte = 8'h0C;
                        3'd2:    cur_byte = 8'h01;
                        default: cur_byte = 8'h06;
                    endcase
                end
            end
            T_CURSOR: cur_byte = 8'h80 | row_base(row_q);
            T_CHARS:  cur_byte = ch;
            default:  cur_byte = '0;
        endcase
    end

    always_comb begin
        active   = (top_q == T_INIT_SEQ) || (top_q == T_CURSOR) || (top_q == T_CHARS);
        last_row = (row_q == RW'(ROWS - 1));
        last_col = (col_q == KW'(COLS - 1));
        wait_end = (top_q == T_INIT_SEQ && cur_byte == 8'h01) ? CLR_END : CMD_END;

        busy   = (top_q != T_IDLE);
        lcd_e  = active && (ph_q == P_EHI);
        lcd_rs = (top_q == T_CHARS);
        lcd_rw = 1'b0;
        lcd_db = '0;
        if (active) begin
            if (BUS4 != 0) lcd_db = {(nib_q ? cur_byte[3:0] : cur_byte[7:4]), 4'h0};
            else           lcd_db = cur_byte;
        end
        done = (top_q == T_CHARS) && (ph_q == P_WAIT) && (cnt_q == wait_end) && last_row && last_col;
    end

    always_comb begin
        top_d    = top_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        nib_d    = nib_q;
        byte_end = 1'b0;
        case (top_q)
            T_INIT_DLY: begin
                if (cnt_q == INIT_END) begin
                    top_d = T_INIT_SEQ;
                    ph_d  = P_SETUP;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            T_IDLE: begin
                if (update) begin
                    top_d = T_CURSOR;
                    ph_d  = P_SETUP;
                    cnt_d = '0;
                    row_d = '0;
                    col_d = '0;
                end
            end
            default: begin
                case (ph_q)
                    P_SETUP: begin
                        ph_d  = P_EHI;
                        cnt_d = '0;
                    end
                    P_EHI: begin
                        if (cnt_q == E_END) ph_d = P_HOLD;
                        else                cnt_d = cnt_q + 1'b1;
                    end
                    P_HOLD: begin
                        cnt_d = '0;
                        if ((BUS4 != 0) && !nib_q && !single) begin
                            nib_d = 1'b1;
                            ph_d  = P_SETUP;
                        end else begin
                            nib_d = 1'b0;
                            ph_d  = P_WAIT;
                        end
                    end
                    default: begin
                        if (cnt_q == wait_end) begin
                            byte_end = 1'b1;
                            cnt_d    = '0;
                            ph_d     = P_SETUP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                endcase
                if (byte_end) begin
                    case (top_q)
                        T_INIT_SEQ: begin
                            if (idx_q == INIT_LAST) begin
                                top_d = T_IDLE;
                                idx_d = '0;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        T_CURSOR: begin
                            top_d = T_CHARS;
                            col_d = '0;
                        end
                        default: begin
                            if (last_col) begin
                                col_d = '0;
                                if (last_row) begin
                                    row_d = '0;
                                    top_d = T_IDLE;
                                end else begin
                                    row_d = row_q + 1'b1;
                                    top_d = T_CURSOR;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: 8-bit and 4-bit instances, transfers checked at each lcd_e fall.
module tb_lcd_text_ctrl;

    localparam int ROWS = 2, COLS = 2, E_CYC = 2, CMD_W = 4, CLR_W = 8, INIT_W = 10;
    localparam int LAT  = ROWS * (COLS + 1) * (E_CYC + 2 + CMD_W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rst4, update;
    logic [31:0] text;
    logic        busy8, done8, e8, rs8, rw8;
    logic [7:0]  db8;
    logic        busy4, done4, e4, rs4, rw4;
    logic [7:0]  db4;

    lcd_text_ctrl #(.ROWS(ROWS), .COLS(COLS), .BUS4(0), .E_CYCLES(E_CYC), .CMD_WAIT(CMD_W),
                    .CLR_WAIT(CLR_W), .INIT_WAIT(INIT_W)) u8 (
        .clk(clk), .reset(reset), .text(text), .update(update), .busy(busy8), .done(done8),
        .lcd_e(e8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_db(db8));

    lcd_text_ctrl #(.ROWS(ROWS), .COLS(COLS), .BUS4(1), .E_CYCLES(E_CYC), .CMD_WAIT(CMD_W),
                    .CLR_WAIT(CLR_W), .INIT_WAIT(INIT_W)) u4 (
        .clk(clk), .reset(rst4), .text(text), .update(update), .busy(busy4), .done(done4),
        .lcd_e(e4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_db(db4));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic [9:0] q8[$];
    logic [9:0] q4[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic       e8_prev = 1'b0;
    logic [8:0] held8;
    always @(negedge clk) begin
        if (reset) begin
            e8_prev = 1'b0;
        end else begin
            if (done8) done_cnt++;
            if (e8 && !e8_prev) held8 = {rs8, db8};
            if (e8 && e8_prev) check("db_stable8", {23'b0, rs8, db8}, {23'b0, held8});
            if (e8_prev && !e8) begin
                if (q8.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL xfer8: unexpected transfer %0h, none required", {rw8, rs8, db8});
                end else begin
                    check("xfer8", {22'b0, rw8, rs8, db8}, {22'b0, q8.pop_front()});
                end
            end
            e8_prev = e8;
        end
    end

    logic e4_prev = 1'b0;
    always @(negedge clk) begin
        if (rst4) begin
            e4_prev = 1'b0;
        end else begin
            check("db4_low_zero", {28'b0, db4[3:0]}, 32'h0);
            if (e4_prev && !e4) begin
                if (q4.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL xfer4: unexpected transfer %0h, none required", {rw4, rs4, db4});
                end else begin
                    check("xfer4", {22'b0, rw4, rs4, db4}, {22'b0, q4.pop_front()});
                end
            end
            e4_prev = e4;
        end
    end

    task automatic push_init8();
        q8.push_back({2'b00, 8'h38});
        q8.push_back({2'b00, 8'h0C});
        q8.push_back({2'b00, 8'h01});
        q8.push_back({2'b00, 8'h06});
    endtask

    task automatic push_frame(input logic [31:0] t);
        for (int r = 0; r < ROWS; r++) begin
            q8.push_back({2'b00, (r == 0) ? 8'h80 : 8'hC0});
            for (int c = 0; c < COLS; c++) q8.push_back({2'b01, t[8*(r*COLS+c) +: 8]});
        end
    endtask

    task automatic run_init8();
        int t0;
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 1);
        check("rst_done", done8, 0);
        check("rst_e", e8, 0);
        check("rst_rs", rs8, 0);
        check("rst_rw", rw8, 0);
        check("rst_db", db8, 0);
        q8.delete();
        push_init8();
        reset = 1'b0;
        t0 = cyc;
        for (n = 1; n < 200; n++) begin
            @(negedge clk);
            if (e8) break;
        end
        check("init_first_e", n, INIT_W + 1);
        for (n = 0; n < 500 && busy8; n++) @(negedge clk);
        check("init_busy_low_cyc", cyc - t0, 46);
        check("init_q_empty", q8.size(), 0);
    endtask

    task automatic start_refresh(input logic [31:0] t, output int t_acc);
        for (int n = 0; n < 1000 && busy8; n++) @(negedge clk);
        check("idle_before_update", busy8, 0);
        text   = t;
        update = 1'b1;
        t_acc  = cyc;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_done(output int t_done);
        for (int n = 0; n < 1000 && !done8; n++) @(negedge clk);
        t_done = cyc;
    endtask

    typedef struct {
        logic [31:0] txt;
        logic [9:0]  exp[6];
    } vec_t;
    vec_t tbl[3];

    initial begin
        int ta, td, t0, t1, t2, d0;
        reset  = 1'b1;
        rst4   = 1'b1;
        update = 1'b0;
        text   = '0;

        tbl[0].txt = 32'h44434241;
        tbl[0].exp = '{10'h080, 10'h141, 10'h142, 10'h0C0, 10'h143, 10'h144};
        tbl[1].txt = 32'h7E20FF00;
        tbl[1].exp = '{10'h080, 10'h100, 10'h1FF, 10'h0C0, 10'h120, 10'h17E};
        tbl[2].txt = 32'h30A55A31;
        tbl[2].exp = '{10'h080, 10'h131, 10'h15A, 10'h0C0, 10'h1A5, 10'h130};

        run_init8();

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 6; j++) q8.push_back(tbl[i].exp[j]);
            start_refresh(tbl[i].txt, ta);
            wait_done(td);
            check("refresh_latency", td - ta, LAT);
            @(negedge clk);
            check("refresh_busy_after", busy8, 0);
            check("refresh_done_1cyc", done8, 0);
            check("refresh_q_empty", q8.size(), 0);
        end

        // frame snapshot must survive a text change plus an update while busy
        push_frame(32'h64636261);
        d0 = done_cnt;
        start_refresh(32'h64636261, ta);
        repeat (12) @(negedge clk);
        text   = 32'h5A5A5A5A;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        wait_done(td);
        check("snap_latency", td - ta, LAT);
        repeat (60) @(negedge clk);
        check("snap_one_done", done_cnt - d0, 1);
        check("snap_q_empty", q8.size(), 0);
        check("snap_idle", busy8, 0);

        // update held high: back-to-back refreshes with a single idle cycle
        push_frame(32'h34333231);
        push_frame(32'h34333231);
        text   = 32'h34333231;
        update = 1'b1;
        ta     = cyc;
        wait_done(t1);
        check("b2b_latency1", t1 - ta, LAT);
        @(negedge clk);
        check("b2b_idle_cycle", busy8, 0);
        @(negedge clk);
        check("b2b_restart", busy8, 1);
        update = 1'b0;
        wait_done(t2);
        check("b2b_period", t2 - t1, LAT + 1);
        repeat (20) @(negedge clk);
        check("b2b_stays_idle", busy8, 0);
        check("b2b_q_empty", q8.size(), 0);

        // reset during the enable-high phase of a data byte
        push_frame(32'h44434241);
        start_refresh(32'h44434241, ta);
        for (int n = 0; n < 200 && !(e8 && rs8); n++) @(negedge clk);
        check("mid_ehi_data", {30'b0, e8, rs8}, 32'h3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_e", e8, 0);
        check("async_rst_busy", busy8, 1);
        check("async_rst_db", db8, 0);
        q8.delete();
        run_init8();
        for (int j = 0; j < 6; j++) q8.push_back(tbl[0].exp[j]);
        start_refresh(tbl[0].txt, ta);
        wait_done(td);
        check("post_rst_latency", td - ta, LAT);
        @(negedge clk);
        check("post_rst_q_empty", q8.size(), 0);

        // 4-bit init sequence
        foreach (tbl[i]) ;
        q4.push_back({2'b00, 4'h3, 4'h0});
        q4.push_back({2'b00, 4'h3, 4'h0});
        q4.push_back({2'b00, 4'h3, 4'h0});
        q4.push_back({2'b00, 4'h2, 4'h0});
        q4.push_back({2'b00, 4'h2, 4'h0});
        q4.push_back({2'b00, 4'h8, 4'h0});
        q4.push_back({2'b00, 4'h0, 4'h0});
        q4.push_back({2'b00, 4'hC, 4'h0});
        q4.push_back({2'b00, 4'h0, 4'h0});
        q4.push_back({2'b00, 4'h1, 4'h0});
        q4.push_back({2'b00, 4'h0, 4'h0});
        q4.push_back({2'b00, 4'h6, 4'h0});
        @(negedge clk);
        check("rst4_busy", busy4, 1);
        rst4 = 1'b0;
        t0   = cyc;
        for (int n = 0; n < 1000 && busy4; n++) @(negedge clk);
        check("init4_busy_low_cyc", cyc - t0, 94);
        check("init4_q_empty", q4.size(), 0);
        rst4 = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
